barrier_pkt_parser: RTL

- Upstream stage of the barrier comm_id lookup table on the NetFPGA datapath.
- Snoops the 64-bit data/ctrl packet stream and identifies barrier packets by ethertype.
- For each barrier packet, extracts comm_id and barrier state, then runs one lookup_req/lookup_ack transaction against the lookup table.
- Presents the old and new barrier state, plus hit/miss, to downstream barrier-decision logic through a valid/ready result handshake.

---
 rtl/barrier_pkt_parser.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/barrier_pkt_parser.sv
// barrier_pkt_parser: snoops the 64-bit NetFPGA packet stream and finds barrier
// packets by ethertype. For each one it runs a single req/ack lookup against
// the comm_id table, then presents old/new state and hit/miss downstream
// through a valid/ready handshake.
module barrier_pkt_parser #(
  parameter int          DATA_WIDTH        = 64,
  parameter int          CTRL_WIDTH        = 8,
  parameter logic [15:0] BARRIER_ETHERTYPE = 16'h88B5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [15:0]           comm_id,
  output logic [2:0]            barrier_state_in,
  output logic                  lookup_req,
  input  logic                  lookup_ack,
  input  logic [2:0]            barrier_state_out,
  input  logic                  lut_hit,
  input  logic                  lut_miss,
  output logic                  result_valid,
  input  logic                  result_rdy,
  output logic [15:0]           result_comm_id,
  output logic [2:0]            result_state_new,
  output logic [2:0]            result_state_old,
  output logic                  result_hit,
  output logic [15:0]           barrier_pkt_cnt,
  output logic [15:0]           short_pkt_cnt
);

  localparam logic [1:0] P_HDR  = 2'd0;
  localparam logic [1:0] P_W1   = 2'd1;
  localparam logic [1:0] P_W2   = 2'd2;
  localparam logic [1:0] P_REST = 2'd3;

  localparam logic [1:0] LK_IDLE = 2'd0;
  localparam logic [1:0] LK_REQ  = 2'd1;
  localparam logic [1:0] LK_REL  = 2'd2;
  localparam logic [1:0] LK_RES  = 2'd3;

  logic [1:0] p_state;
  logic [1:0] lk_state;
  logic       eth_match;
  logic       ack_armed;
  logic       word_acc;
  logic       is_ctrl;
  logic       start_lookup;

  // Payload bits outside the ethertype/comm_id/state fields, and the miss
  // flag (the complement of hit), carry nothing this block needs.
  logic unused_ok;
  assign unused_ok = ^{in_data[44:32], in_data[15:0], lut_miss};

  // Only the W2 word is held back, and only while a lookup is outstanding.
  assign in_rdy       = (lk_state == LK_IDLE) || (p_state != P_W2);
  assign word_acc     = in_wr & in_rdy;
  assign is_ctrl      = (in_ctrl != '0);
  assign start_lookup = word_acc && (p_state == P_W2) && !is_ctrl && eth_match;

  assign lookup_req       = (lk_state == LK_REQ);
  assign result_valid     = (lk_state == LK_RES);
  // The request fields only change on a start, which cannot happen until the
  // previous result is consumed, so they double as the result fields.
  assign result_comm_id   = comm_id;
  assign result_state_new = barrier_state_in;

  // Parse FSM: walks header/W0/W1/W2/rest of each packet on accepted words.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_state          <= P_HDR;
      eth_match        <= 1'b0;
      short_pkt_cnt    <= '0;
      comm_id          <= '0;
      barrier_state_in <= '0;
    end else if (word_acc) begin
      case (p_state)
        P_HDR: begin
          if (!is_ctrl) p_state <= P_W1;
        end
        P_W1: begin
          if (is_ctrl) begin
            short_pkt_cnt <= short_pkt_cnt + 16'd1;
            p_state       <= P_HDR;
          end else begin
            eth_match <= (in_data[31:16] == BARRIER_ETHERTYPE);
            p_state   <= P_W2;
          end
        end
        P_W2: begin
          if (is_ctrl) begin
            short_pkt_cnt <= short_pkt_cnt + 16'd1;
            p_state       <= P_HDR;
          end else begin
            if (eth_match) begin
              comm_id          <= in_data[63:48];
              barrier_state_in <= in_data[47:45];
            end
            p_state <= P_REST;
          end
        end
        default: begin
          if (is_ctrl) p_state <= P_HDR;
        end
      endcase
    end
  end

  // Lookup FSM: req/ack with the table, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      lk_state         <= LK_IDLE;
      ack_armed        <= 1'b0;
      result_state_old <= '0;
      result_hit       <= 1'b0;
      barrier_pkt_cnt  <= '0;
    end else begin
      case (lk_state)
        LK_IDLE: begin
          if (start_lookup) begin
            lk_state  <= LK_REQ;
            // A still-high ack from the table is stale; require it to fall
            // before a high level counts as the ack for this request.
            ack_armed <= !lookup_ack;
          end
        end
        LK_REQ: begin
          if (lookup_ack && ack_armed) begin
            result_state_old <= barrier_state_out;
            result_hit       <= lut_hit;
            lk_state         <= LK_REL;
          end else if (!lookup_ack) begin
            ack_armed <= 1'b1;
          end
        end
        LK_REL: begin
          if (!lookup_ack) lk_state <= LK_RES;
        end
        default: begin
          if (result_rdy) begin
            barrier_pkt_cnt <= barrier_pkt_cnt + 16'd1;
            lk_state        <= LK_IDLE;
          end
        end
      endcase
    end
  end

endmodule
